serial_byte_transmitter: RTL and testbench
==========================================

# serial_byte_transmitter

UART transmit stage (8N1, optional parity) that serialises one byte at a time onto the `tx` line. It sits directly downstream of the fixed-point number encoder and consumes its `transmit_byte` / `transmit_ready` / `transmit_available` handshake. It is the last on-chip stage before the board's serial pin. Baud rate is set by an integer clocks-per-bit divider.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal values are 2 or more.
- `COUNT_BITS`, default 9: width of the bit-period counter. Must satisfy `2**COUNT_BITS >= CLKS_PER_BIT`.

Ports:
- `clk`, input, 1: sole clock; every register updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `transmit_byte`, input, 8: byte to send. Sampled only on acceptance.
- `transmit_ready`, input, 1: single-cycle request pulse from upstream.
- `transmit_available`, output, 1: high when idle and able to accept a byte.
- `tx`, output, 1: serial line, idle high.

## Operation
- States:
  - IDLE
  - START
  - DATA
  - PARITY (only with the macro)
  - STOP
- Acceptance:
  - When in IDLE and `transmit_ready` is 1 at a clock edge, latch `transmit_byte` into the shift register.
  - Clear `clk_count` and `bit_index`, then go to START.
  - `transmit_ready` in any other state is ignored and has no effect.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - `tx` = latched bit `bit_index`, LSB first (bit 0 is sent first, matching the encoder's little-endian byte order).
  - Each bit is held `CLKS_PER_BIT` cycles.
  - `bit_index` runs 0..7. After bit 7's period, go to PARITY (if enabled), otherwise STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- `clk_count` counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each state or bit advance.
- `transmit_available` = 1 only in IDLE.
- `tx` is registered and is 1 in IDLE.
- The latched byte is held for the whole frame. Upstream changes to `transmit_byte` after acceptance do not affect the frame.
- Reset mid-frame: the frame is aborted with no completion of the stop bit.
  - Next cycle: state IDLE, `tx`=1, `transmit_available`=1.
  - The partial frame is simply truncated.

## Timing
- Reset values, visible the cycle after `reset` is sampled high:
  - `tx`=1
  - `transmit_available`=1
  - state IDLE
  - `clk_count`=0
  - `bit_index`=0
  - shift register 0
- Acceptance at edge T:
  - From T+1: `transmit_available`=0 and `tx`=0 (start bit).
  - This drop within one cycle is required. The upstream encoder detects completion as a rising edge of `transmit_available`.
- Frame length: start bit begins at T+1.
  - Without parity, 10×`CLKS_PER_BIT` cycles.
  - With parity, 11×`CLKS_PER_BIT` cycles.
- `transmit_available` returns to 1 on the first cycle after the stop-bit period, i.e. at T+1+frame length.
- Back-to-back: with the encoder in the loop, the next `transmit_ready` arrives one cycle after `transmit_available` rises.
  - The next start bit begins two cycles after that rise.
  - The idle-high gap stretches the stop bit; this is legal UART framing.
- `transmit_ready` coinciding with `reset`: reset wins and the byte is not accepted.

## Configuration
- `SERIAL_TX_PARITY_EN`
  - Defined: PARITY state is inserted after bit 7. `tx` = XOR of the 8 latched bits (even parity) for `CLKS_PER_BIT` cycles; frame is 11 bit-times.
  - Undefined: PARITY state and parity logic are absent; frame is 8N1, 10 bit-times.

## Test plan
- **Single frame.** `CLKS_PER_BIT`=4, reset, then `transmit_ready` pulse with `transmit_byte`=8'hA5 at edge T.
  - `tx` sequence per 4-cycle slot from T+1: 0, 1,0,1,0,0,1,0,1, 1.
  - `transmit_available` is 0 from T+1 through T+40 and 1 at T+41.
- **Busy ignore.** During the frame above, pulse `transmit_ready` with 8'hFF at T+10.
  - Waveform is unchanged; no second frame follows.
- **Byte latch.** Change `transmit_byte` to 8'h00 at T+2.
  - Transmitted data is still 8'hA5.
- **Reset mid-frame.** Assert `reset` at T+20 for one cycle.
  - At T+21: `tx`=1 and `transmit_available`=1.
  - A new 8'h3C accepted at T+25 produces a clean full frame.
- **Encoder chain.** Connect to the 37-bit / 5-byte encoder, `CLKS_PER_BIT`=4, `num`=37'h1_2345_6789.
  - Decoded `tx` bytes in order: 89, 67, 45, 23, 01.
  - Encoder `available` returns to 1 after the fifth frame.
- **Parity (with `SERIAL_TX_PARITY_EN`).**
  - 8'hA5 gives parity slot `tx`=0 and a 44-cycle frame.
  - 8'h07 gives parity slot `tx`=1.

Source files
------------

// File: rtl/serial_byte_transmitter_if.sv
// rtl/serial_byte_transmitter_if.sv - byte handshake between upstream encoder and UART transmitter
interface serial_byte_transmitter_if;
    logic [7:0] transmit_byte;
    logic       transmit_ready;
    logic       transmit_available;

    modport master (
        output transmit_byte,
        output transmit_ready,
        input  transmit_available
    );

    modport slave (
        input  transmit_byte,
        input  transmit_ready,
        output transmit_available
    );
endinterface

// File: rtl/serial_byte_transmitter.sv
// rtl/serial_byte_transmitter.sv - UART 8N1 transmit stage; define SERIAL_TX_PARITY_EN for an even-parity bit
module serial_byte_transmitter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int COUNT_BITS   = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    serial_byte_transmitter_if.slave   tif,
    output logic                       tx
);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [COUNT_BITS-1:0] LAST_COUNT = COUNT_BITS'(CLKS_PER_BIT - 1);

    state_t                state;
    logic [COUNT_BITS-1:0] clk_count;
    logic [2:0]            bit_index;
    logic [7:0]            data_reg;
    logic                  available_q;

    assign tif.transmit_available = available_q;

    // tx and available are computed one state ahead so both change on the
    // same edge as the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tx          <= 1'b1;
            available_q <= 1'b1;
            clk_count   <= '0;
            bit_index   <= '0;
            data_reg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx          <= 1'b1;
                    available_q <= 1'b1;
                    clk_count   <= '0;
                    bit_index   <= '0;
                    if (tif.transmit_ready) begin
                        data_reg    <= tif.transmit_byte;
                        state       <= START;
                        tx          <= 1'b0;
                        available_q <= 1'b0;
                    end
                end
                START: begin
                    if (clk_count == LAST_COUNT) begin
                        clk_count <= '0;
                        state     <= DATA;
                        tx        <= data_reg[0];
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_count == LAST_COUNT) begin
                        clk_count <= '0;
                        if (bit_index == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= ^data_reg;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_index <= bit_index + 3'd1;
                            tx        <= data_reg[bit_index + 3'd1];
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (clk_count == LAST_COUNT) begin
                        clk_count <= '0;
                        state     <= STOP;
                        tx        <= 1'b1;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (clk_count == LAST_COUNT) begin
                        clk_count   <= '0;
                        state       <= IDLE;
                        available_q <= 1'b1;
                        tx          <= 1'b1;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    tx          <= 1'b1;
                    available_q <= 1'b1;
                    clk_count   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_byte_transmitter.sv
// tb/tb_serial_byte_transmitter.sv - directed bench for serial_byte_transmitter at 4 clocks per bit
module tb_serial_byte_transmitter;

    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NSLOT = 11;
`else
    localparam int NSLOT = 10;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx;

    serial_byte_transmitter_if tif();

    serial_byte_transmitter #(.CLKS_PER_BIT(CPB), .COUNT_BITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .tif   (tif),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] b;
        logic [9:0] exp_frame;   // slot i at bit i: start, d0..d7, stop
        logic       exp_par;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tif.transmit_byte  = b;
        tif.transmit_ready = 1'b1;
        @(posedge clk);
        #1 tif.transmit_ready = 1'b0;
    endtask

    // Called right after the acceptance edge; returns at the negedge of the
    // first cycle after the frame.
    task automatic capture(output logic [9:0] fr, output logic par, output int low,
                           output logic avail_end, output logic stable);
        logic [10:0] slots;
        logic seen_high;
        slots = '0;
        low = 0;
        stable = 1'b1;
        seen_high = 1'b0;
        for (int k = 0; k < NSLOT * CPB; k++) begin
            @(negedge clk);
            if (k % CPB == 0) slots[k / CPB] = tx;
            else if (tx !== slots[k / CPB]) stable = 1'b0;
            if (!tif.transmit_available && !seen_high) low++;
            else seen_high = 1'b1;
        end
        @(negedge clk);
        avail_end = tif.transmit_available;
`ifdef SERIAL_TX_PARITY_EN
        fr  = {slots[10], slots[8:0]};
        par = slots[9];
`else
        fr  = slots[9:0];
        par = 1'b0;
`endif
    endtask

    initial begin
        logic [9:0] fr;
        logic par, avail_end, stable, idle_ok;
        int low;

        vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
        vecs[1] = '{8'h07, 10'b1_00000111_0, 1'b1};
        vecs[2] = '{8'h89, 10'b1_10001001_0, 1'b1};
        vecs[3] = '{8'h67, 10'b1_01100111_0, 1'b1};
        vecs[4] = '{8'h45, 10'b1_01000101_0, 1'b1};
        vecs[5] = '{8'h23, 10'b1_00100011_0, 1'b1};
        vecs[6] = '{8'h01, 10'b1_00000001_0, 1'b1};
        vecs[7] = '{8'h80, 10'b1_10000000_0, 1'b1};

        tif.transmit_byte  = 8'h00;
        tif.transmit_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_available", tif.transmit_available, 1);

        // Back-to-back frames, next request one cycle after available rises
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].b);
            capture(fr, par, low, avail_end, stable);
            check($sformatf("frame[%0d]", i), fr, vecs[i].exp_frame);
`ifdef SERIAL_TX_PARITY_EN
            check($sformatf("parity[%0d]", i), par, vecs[i].exp_par);
`endif
            check($sformatf("busy_cycles[%0d]", i), low, NSLOT * CPB);
            check($sformatf("avail_end[%0d]", i), avail_end, 1);
            check($sformatf("slot_stable[%0d]", i), stable, 1);
        end

        // Busy ignore and byte latch during an A5 frame
        send(8'hA5);
        fork
            capture(fr, par, low, avail_end, stable);
            begin
                @(negedge clk);
                tif.transmit_byte = 8'h00;
                repeat (8) @(negedge clk);
                tif.transmit_byte  = 8'hFF;
                tif.transmit_ready = 1'b1;
                @(negedge clk);
                tif.transmit_ready = 1'b0;
            end
        join
        check("latch_frame", fr, 10'b1_10100101_0);
        check("latch_busy_cycles", low, NSLOT * CPB);
        idle_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tif.transmit_available !== 1'b1) idle_ok = 1'b0;
        end
        check("no_second_frame", idle_ok, 1);

        // Reset mid-frame, then a clean frame
        send(8'hA5);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_tx", tx, 1);
        check("midreset_available", tif.transmit_available, 1);
        repeat (3) @(negedge clk);
        send(8'h3C);
        capture(fr, par, low, avail_end, stable);
        check("after_reset_frame", fr, 10'b1_00111100_0);
`ifdef SERIAL_TX_PARITY_EN
        check("after_reset_parity", par, 0);
`endif
        check("after_reset_busy", low, NSLOT * CPB);
        check("after_reset_avail", avail_end, 1);

        // Request coinciding with reset is dropped
        @(negedge clk);
        reset = 1'b1;
        tif.transmit_byte  = 8'h55;
        tif.transmit_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tif.transmit_ready = 1'b0;
        idle_ok = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (tx !== 1'b1 || tif.transmit_available !== 1'b1) idle_ok = 1'b0;
            @(negedge clk);
        end
        check("reset_wins_over_ready", idle_ok, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
